// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-RAM port arbiter.
//               gnt_e names the two requesters (fetch, load/store).
//               arb_state_e names the port state (free / read in flight).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Requester identity; also used as the round-robin history value and the
    // owner tag of an in-flight read.
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    // Port state: IDLE = RAM port free, BUSY = a read is in flight.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Bit positions of the requesters inside the req/gnt vectors.
    localparam int unsigned C_REQ_IF  = 0;
    localparam int unsigned C_REQ_MEM = 1;

    // Latency counter width; RD_LAT is limited to 1..4, so 3 bits suffice.
    localparam int unsigned C_CNT_W = 3;

    // Map a one-hot grant vector to the requester identity.
    function automatic gnt_e gnt_to_id(input logic [1:0] gnt);
        return gnt[C_REQ_MEM] ? GNT_MEM : GNT_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin grant. Grants only while the shared
//               port is free. On a conflict, the requester that did not win
//               the previous handshake wins. The history register changes
//               only on an actual handshake (fire_i).
// Ports       : clk, rst    - clock, synchronous active-high reset
//               req_i[1:0]  - request vector (bit0 = IF, bit1 = MEM)
//               free_i      - shared port can accept a request this cycle
//               fire_i      - a handshake happens this cycle
//               gnt_o[1:0]  - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       free_i,
    input  logic       fire_i,
    output logic [1:0] gnt_o
);

    gnt_e last_gnt_q;
    gnt_e last_gnt_d;

    always_comb begin
        gnt_o = 2'b00;
        if (free_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Conflict: favour whoever did not win last time.
                2'b11:   gnt_o = (last_gnt_q == GNT_IF) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (fire_i && (gnt_o != 2'b00)) begin
            last_gnt_d = gnt_to_id(gnt_o);
        end
    end

    // Reset history to IF so the first conflict after reset goes to MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, synchronous-read RAM between the
//               fetch stage (read-only) and the load/store stage. It grants
//               one request per free slot, with round-robin on conflict. It
//               tracks the fixed read latency and steers each read response
//               back to the requester that issued it.
// Parameters  : ADDR_W - address width
//               DATA_W - data width (byte strobes are DATA_W/8)
//               RD_LAT - RAM read latency in cycles, 1..4
// Ports       : clk, rst                  - clock, sync active-high reset
//               if_req_*_i / if_req_ready_o   - fetch request channel
//               if_resp_*_o                   - fetch read response
//               mem_req_*_i / mem_req_ready_o - load/store request channel
//               mem_resp_*_o                  - load response
//               ram_*_o / ram_rdata_i         - RAM macro interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    // Fetch port
    input  logic                if_req_valid_i,
    input  logic [ADDR_W-1:0]   if_req_addr_i,
    output logic                if_req_ready_o,
    output logic                if_resp_valid_o,
    output logic [DATA_W-1:0]   if_resp_data_o,
    // Load/store port
    input  logic                mem_req_valid_i,
    input  logic                mem_req_we_i,
    input  logic [ADDR_W-1:0]   mem_req_addr_i,
    input  logic [DATA_W-1:0]   mem_req_wdata_i,
    input  logic [DATA_W/8-1:0] mem_req_wstrb_i,
    output logic                mem_req_ready_o,
    output logic                mem_resp_valid_o,
    output logic [DATA_W-1:0]   mem_resp_data_o,
    // RAM macro
    output logic                ram_en_o,
    output logic [DATA_W/8-1:0] ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    localparam logic [C_CNT_W-1:0] C_LAT_CNT = C_CNT_W'(RD_LAT);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    gnt_e               owner_q;
    gnt_e               owner_d;

    // ------------------------------------------------------------------
    // Grant / handshake decode
    // ------------------------------------------------------------------
    logic       w_resp_cycle;
    logic       w_free;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_if_win;
    logic       w_mem_win;
    logic       w_fire;
    logic       w_store;
    logic       w_read_fire;
    logic       w_resp;

    // The response cycle doubles as a free slot so reads can issue
    // back-to-back at full throughput.
    assign w_resp_cycle = (state_q == ARB_BUSY) && (cnt_q == C_LAT_CNT);
    assign w_free       = (state_q == ARB_IDLE) || w_resp_cycle;
    assign w_req        = {mem_req_valid_i, if_req_valid_i};

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .rst    (rst),
        .req_i  (w_req),
        .free_i (w_free),
        .fire_i (w_fire),
        .gnt_o  (w_gnt)
    );

    // A grant is only issued to a valid requester, so a (reset-qualified)
    // grant is already a handshake.
    assign w_if_win    = w_gnt[C_REQ_IF]  && !rst;
    assign w_mem_win   = w_gnt[C_REQ_MEM] && !rst;
    assign w_fire      = w_if_win || w_mem_win;
    assign w_store     = w_mem_win && mem_req_we_i;
    assign w_read_fire = w_fire && !w_store;
    assign w_resp      = w_resp_cycle && !rst;

    // ------------------------------------------------------------------
    // Request-side outputs and RAM muxing
    // ------------------------------------------------------------------
    always_comb begin
        if_req_ready_o  = w_if_win;
        mem_req_ready_o = w_mem_win;
        ram_en_o        = w_fire;
        ram_we_o        = '0;
        ram_addr_o      = '0;
        ram_wdata_o     = '0;
        if (w_mem_win) begin
            ram_addr_o  = mem_req_addr_i;
            ram_wdata_o = mem_req_wdata_i;
            // A zero strobe is still a granted slot; it just writes nothing.
            if (mem_req_we_i) begin
                ram_we_o = mem_req_wstrb_i;
            end
        end else if (w_if_win) begin
            ram_addr_o = if_req_addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Response steering: RAM data goes only to the owner of the read.
    // ------------------------------------------------------------------
    always_comb begin
        if_resp_valid_o  = w_resp && (owner_q == GNT_IF);
        mem_resp_valid_o = w_resp && (owner_q == GNT_MEM);
        if_resp_data_o   = if_resp_valid_o  ? ram_rdata_i : '0;
        mem_resp_data_o  = mem_resp_valid_o ? ram_rdata_i : '0;
    end

    // ------------------------------------------------------------------
    // Port FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (w_read_fire) begin
            // New read (possibly in the response cycle of the previous one).
            state_d = ARB_BUSY;
            cnt_d   = C_CNT_ONE;
            owner_d = w_mem_win ? GNT_MEM : GNT_IF;
        end else if (state_q == ARB_BUSY) begin
            if (w_resp_cycle) begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
        end
    end

    // Reset drops any in-flight read so no stale response appears later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            owner_q <= GNT_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A RAM model
//               answers the DUT's RAM port. A time-based reference model
//               (port-free time, last winner, reference memory) predicts
//               readies, RAM strobes and read responses. Expected responses
//               are queued and popped by an independent response monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               if_req_valid = 1'b0;
    logic [ADDR_W-1:0]  if_req_addr = '0;
    logic               if_req_ready;
    logic               if_resp_valid;
    logic [DATA_W-1:0]  if_resp_data;
    logic               mem_req_valid = 1'b0;
    logic               mem_req_we = 1'b0;
    logic [ADDR_W-1:0]  mem_req_addr = '0;
    logic [DATA_W-1:0]  mem_req_wdata = '0;
    logic [STRB_W-1:0]  mem_req_wstrb = '0;
    logic               mem_req_ready;
    logic               mem_resp_valid;
    logic [DATA_W-1:0]  mem_resp_data;
    logic               ram_en;
    logic [STRB_W-1:0]  ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req_valid_i   (if_req_valid),
        .if_req_addr_i    (if_req_addr),
        .if_req_ready_o   (if_req_ready),
        .if_resp_valid_o  (if_resp_valid),
        .if_resp_data_o   (if_resp_data),
        .mem_req_valid_i  (mem_req_valid),
        .mem_req_we_i     (mem_req_we),
        .mem_req_addr_i   (mem_req_addr),
        .mem_req_wdata_i  (mem_req_wdata),
        .mem_req_wstrb_i  (mem_req_wstrb),
        .mem_req_ready_o  (mem_req_ready),
        .mem_resp_valid_o (mem_resp_valid),
        .mem_resp_data_o  (mem_resp_data),
        .ram_en_o         (ram_en),
        .ram_we_o         (ram_we),
        .ram_addr_o       (ram_addr),
        .ram_wdata_o      (ram_wdata),
        .ram_rdata_i      (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM model: 16 words indexed by addr[5:2], read data appears RD_LAT
    // cycles after the access. Non-read slots shift in random garbage.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tb_ram  [16];
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] pipe    [1:RD_LAT];

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_ram[i]  = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    always @(posedge clk) begin
        pipe[1] <= (ram_en && ram_we == '0) ? tb_ram[ram_addr[5:2]] : DATA_W'($urandom);
        for (int k = 2; k <= int'(RD_LAT); k++) pipe[k] <= pipe[k-1];
        if (ram_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (ram_we[b]) tb_ram[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end
    assign ram_rdata = pipe[RD_LAT];

    // ------------------------------------------------------------------
    // Reference model: port is free from cycle free_at onward; a read
    // occupies it up to (and frees it in) its response cycle, a store for
    // one cycle only.
    // ------------------------------------------------------------------
    typedef struct {
        int                due;
        bit                to_mem;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int free_at  = 0;
    bit last_mem = 1'b0;

    always @(negedge clk) begin
        int win; // 0 none, 1 IF, 2 MEM
        if (rst) begin
            exp_q.delete();
            free_at  = 0;
            last_mem = 1'b0;
        end else begin
            win = 0;
            if (cyc >= free_at) begin
                if (if_req_valid && mem_req_valid) win = last_mem ? 1 : 2;
                else if (if_req_valid)             win = 1;
                else if (mem_req_valid)            win = 2;
            end
            chk("if_req_ready", 64'(if_req_ready), 64'(win == 1));
            chk("mem_req_ready", 64'(mem_req_ready), 64'(win == 2));
            if (win == 0) begin
                chk("ram_en_idle", 64'(ram_en), 64'd0);
            end else begin
                chk("ram_en", 64'(ram_en), 64'd1);
                last_mem = (win == 2);
                if (win == 2 && mem_req_we) begin
                    chk("ram_addr_st", 64'(ram_addr), 64'(mem_req_addr));
                    chk("ram_we_st", 64'(ram_we), 64'(mem_req_wstrb));
                    chk("ram_wdata", 64'(ram_wdata), 64'(mem_req_wdata));
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (mem_req_wstrb[b])
                            ref_mem[mem_req_addr[5:2]][8*b +: 8] = mem_req_wdata[8*b +: 8];
                    end
                    free_at = cyc + 1;
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = (win == 2) ? mem_req_addr : if_req_addr;
                    chk("ram_addr_rd", 64'(ram_addr), 64'(a));
                    chk("ram_we_rd", 64'(ram_we), 64'd0);
                    exp_q.push_back('{due: cyc + int'(RD_LAT), to_mem: (win == 2),
                                      data: ref_mem[a[5:2]]});
                    free_at = cyc + int'(RD_LAT);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            chk("outputs_in_reset",
                64'({if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid, ram_en, ram_we,
                     |if_resp_data, |mem_resp_data, |ram_addr, |ram_wdata}), 64'd0);
        end else if (if_resp_valid || mem_resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.due));
                chk("if_resp_valid", 64'(if_resp_valid), 64'(!e.to_mem));
                chk("mem_resp_valid", 64'(mem_resp_valid), 64'(e.to_mem));
                chk("resp_data", 64'(e.to_mem ? mem_resp_data : if_resp_data), 64'(e.data));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("missing_resp", 64'd0, 64'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        return ADDR_W'($urandom) & 32'hF000_003C;
    endfunction

    task automatic idle(input int n);
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // Single fetch read.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h1C00_0000;
        tick();
        idle(RD_LAT + 1);

        // Partial store followed immediately by a fetch read of the same word.
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = 32'h0000_0010;
        mem_req_wdata = 32'hDEAD_BEEF;
        mem_req_wstrb = 4'b0011;
        tick();
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h0000_0010;
        tick();
        idle(RD_LAT + 1);

        // Fetch read with a load waiting for the response slot.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0024;
        tick();
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h0000_0008;
        repeat (RD_LAT) tick();
        idle(RD_LAT + 1);

        // Continuous conflict: grants alternate.
        for (int c = 0; c < 4 * int'(RD_LAT); c++) begin
            if_req_valid  = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b0;
            if_req_addr   = rnd_addr();
            mem_req_addr  = rnd_addr();
            tick();
        end
        idle(RD_LAT + 1);

        // Reset in the middle of a read, then a conflict.
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0030;
        tick();
        if_req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        if_req_valid  = 1'b1;
        mem_req_valid = 1'b1;
        if_req_addr   = 32'h0000_0004;
        mem_req_addr  = 32'h0000_000C;
        tick();
        idle(RD_LAT + 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            if_req_valid  = ($urandom_range(0, 9) < 6);
            if_req_addr   = rnd_addr();
            mem_req_valid = ($urandom_range(0, 9) < 6);
            mem_req_we    = ($urandom_range(0, 2) == 0);
            mem_req_addr  = rnd_addr();
            mem_req_wdata = DATA_W'($urandom);
            mem_req_wstrb = STRB_W'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        idle(RD_LAT + 3);

        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
